uart_rx_cfg: RTL and testbench

Second-generation UART receiver with run-time frame configuration: data length (5..MAX_DATA_WIDTH), optional even/odd parity, and 1 or 2 stop bits. Each bit is resolved by a 3-sample majority vote. Line breaks are detected. Received frames are delivered through a valid/ack holding register with overrun detection. It sits between the RX pad and the system controller, replacing the fixed-format receiver.

---
 rtl/uart_rx_cfg_if.sv | 30 +++
 rtl/uart_rx_cfg.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cfg_if.sv
// ============================================================================
// Module   : uart_rx_cfg_if
// Brief    : Frame delivery bus between uart_rx_cfg and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_cfg_if #(
  parameter int MAX_DATA_WIDTH = 9
) ();
  logic [MAX_DATA_WIDTH-1:0] P_Data;
  logic                      Data_Valid;
  logic                      Data_Ack;
  logic                      parity_error;
  logic                      framing_error;
  logic                      overrun_error;
  logic                      break_det;

  modport master (
    output P_Data, Data_Valid, parity_error, framing_error, overrun_error, break_det,
    input  Data_Ack
  );

  modport slave (
    input  P_Data, Data_Valid, parity_error, framing_error, overrun_error, break_det,
    output Data_Ack
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Run-time configurable UART receiver, 3-sample majority voting,
//            break detection and a valid/ack holding register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_cfg #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_MAX   = 32
) (
  input  wire logic                              CLK,
  input  wire logic                              RST,
  input  wire logic                              RX_IN,
  input  wire logic [$clog2(PRESCALE_MAX):0]     Prescale,
  input  wire logic [$clog2(MAX_DATA_WIDTH):0]   Data_Len,
  input  wire logic                              PAR_EN,
  input  wire logic                              PAR_TYP,
  input  wire logic                              STP_2,
  output logic                                   busy,
  uart_rx_cfg_if.master                          rx_bus
);

  localparam int c_pw = $clog2(PRESCALE_MAX) + 1;
  localparam int c_lw = $clog2(MAX_DATA_WIDTH) + 1;

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_start    = 3'd1;
  localparam logic [2:0] c_data     = 3'd2;
  localparam logic [2:0] c_parity   = 3'd3;
  localparam logic [2:0] c_stop     = 3'd4;
  localparam logic [2:0] c_brk_wait = 3'd5;

  logic                      r_rx_meta;
  logic                      r_rx_s;
  logic [2:0]                r_state;
  logic [c_pw-1:0]           r_edge_cnt;
  logic [c_lw-1:0]           r_bit_cnt;
  logic [c_pw-1:0]           r_prescale;
  logic [c_lw-1:0]           r_data_len;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_stp_2;
  logic                      r_s0;
  logic                      r_s1;
  logic                      r_s2;
  logic [MAX_DATA_WIDTH-1:0] r_shadow;
  logic                      r_data_xor;
  logic                      r_data_any;
  logic                      r_par_err;
  logic                      r_par_one;
  logic                      r_frm_err;
  logic                      r_stop0_zero;

  logic [MAX_DATA_WIDTH-1:0] r_p_data;
  logic                      r_valid;
  logic                      r_pe;
  logic                      r_fe;
  logic                      r_ovr;
  logic                      r_brk;

  logic [c_pw-1:0] w_half;
  logic [c_pw-1:0] w_samp_a;
  logic [c_pw-1:0] w_samp_b;
  logic [c_pw-1:0] w_samp_c;
  logic [c_pw-1:0] w_decide_pt;
  logic            w_in_frame;
  logic            w_bit_end;
  logic            w_decide;
  logic            w_bit;
  logic            w_last_data;
  logic            w_last_stop;
  logic            w_commit;
  logic            w_break;
  logic            w_frm_now;

  assign w_half      = {1'b0, r_prescale[c_pw-1:1]};
  assign w_samp_a    = w_half - c_pw'(1);
  assign w_samp_b    = w_half;
  assign w_samp_c    = w_half + c_pw'(1);
  assign w_decide_pt = w_half + c_pw'(2);
  assign w_in_frame  = (r_state == c_start) || (r_state == c_data) ||
                       (r_state == c_parity) || (r_state == c_stop);
  assign w_bit_end   = (r_edge_cnt == r_prescale - c_pw'(1));
  assign w_decide    = w_in_frame && (r_edge_cnt == w_decide_pt);
  assign w_bit       = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
  assign w_last_data = (r_bit_cnt == r_data_len - c_lw'(1));
  assign w_last_stop = r_stp_2 ? (r_bit_cnt == c_lw'(1)) : 1'b1;
  assign w_commit    = (r_state == c_stop) && w_decide && w_last_stop;
  assign w_frm_now   = r_frm_err | ~w_bit;
  // With one stop bit the current decision is the first stop bit.
  assign w_break     = ~r_data_any & ~(r_par_en & r_par_one) &
                       (r_stp_2 ? r_stop0_zero : ~w_bit);

  assign busy                 = (r_state != c_idle);
  assign rx_bus.P_Data        = r_p_data;
  assign rx_bus.Data_Valid    = r_valid;
  assign rx_bus.parity_error  = r_pe;
  assign rx_bus.framing_error = r_fe;
  assign rx_bus.overrun_error = r_ovr;
  assign rx_bus.break_det     = r_brk;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_state      <= c_idle;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_prescale   <= '0;
      r_data_len   <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_stp_2      <= 1'b0;
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_shadow     <= '0;
      r_data_xor   <= 1'b0;
      r_data_any   <= 1'b0;
      r_par_err    <= 1'b0;
      r_par_one    <= 1'b0;
      r_frm_err    <= 1'b0;
      r_stop0_zero <= 1'b0;
    end else begin
      r_rx_meta <= RX_IN;
      r_rx_s    <= r_rx_meta;

      if (r_edge_cnt == w_samp_a) r_s0 <= r_rx_s;
      if (r_edge_cnt == w_samp_b) r_s1 <= r_rx_s;
      if (r_edge_cnt == w_samp_c) r_s2 <= r_rx_s;

      if (w_in_frame) r_edge_cnt <= w_bit_end ? '0 : r_edge_cnt + c_pw'(1);

      case (r_state)
        c_idle: begin
          if (!r_rx_s) begin
            // This cycle is edge 0 of the start bit.
            r_state      <= c_start;
            r_edge_cnt   <= c_pw'(1);
            r_bit_cnt    <= '0;
            r_prescale   <= Prescale;
            r_data_len   <= Data_Len;
            r_par_en     <= PAR_EN;
            r_par_typ    <= PAR_TYP;
            r_stp_2      <= STP_2;
            r_shadow     <= '0;
            r_data_xor   <= 1'b0;
            r_data_any   <= 1'b0;
            r_par_err    <= 1'b0;
            r_par_one    <= 1'b0;
            r_frm_err    <= 1'b0;
            r_stop0_zero <= 1'b0;
          end
        end
        c_start: begin
          if (w_decide && w_bit) begin
            r_state    <= c_idle;
            r_edge_cnt <= '0;
          end else if (w_bit_end) begin
            r_state   <= c_data;
            r_bit_cnt <= '0;
          end
        end
        c_data: begin
          if (w_decide) begin
            for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
              if (r_bit_cnt == c_lw'(i)) r_shadow[i] <= w_bit;
            end
            r_data_xor <= r_data_xor ^ w_bit;
            r_data_any <= r_data_any | w_bit;
          end
          if (w_bit_end) begin
            if (w_last_data) begin
              r_state   <= r_par_en ? c_parity : c_stop;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_lw'(1);
            end
          end
        end
        c_parity: begin
          if (w_decide) begin
            r_par_one <= w_bit;
            r_par_err <= ((r_data_xor ^ w_bit) != r_par_typ);
          end
          if (w_bit_end) begin
            r_state   <= c_stop;
            r_bit_cnt <= '0;
          end
        end
        c_stop: begin
          if (w_decide) begin
            if (!w_bit) r_frm_err <= 1'b1;
            if (r_bit_cnt == '0) r_stop0_zero <= ~w_bit;
            if (w_last_stop) begin
              r_state    <= w_break ? c_brk_wait : c_idle;
              r_edge_cnt <= '0;
            end
          end else if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + c_lw'(1);
          end
        end
        c_brk_wait: begin
          if (r_rx_s) r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // Holding register: a commit coincident with an ack replaces the held frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_p_data <= '0;
      r_valid  <= 1'b0;
      r_pe     <= 1'b0;
      r_fe     <= 1'b0;
      r_ovr    <= 1'b0;
      r_brk    <= 1'b0;
    end else begin
      r_brk <= w_commit & w_break;
      if (w_commit && !w_break) begin
        if (!r_valid || rx_bus.Data_Ack) begin
          r_p_data <= r_shadow;
          r_pe     <= r_par_en & r_par_err;
          r_fe     <= w_frm_now;
          r_valid  <= 1'b1;
          if (r_valid) r_ovr <= 1'b0;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_bus.Data_Ack) begin
        r_valid <= 1'b0;
        r_pe    <= 1'b0;
        r_fe    <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Scoreboard bench for uart_rx_cfg with directed serial frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic [4:0] data_len = 5'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       stp_2 = 1'b0;
  logic       busy;

  uart_rx_cfg_if #(.MAX_DATA_WIDTH(9)) bus ();

  uart_rx_cfg #(.MAX_DATA_WIDTH(9), .PRESCALE_MAX(32)) dut (
    .CLK      (clk),
    .RST      (rst),
    .RX_IN    (rx_in),
    .Prescale (prescale),
    .Data_Len (data_len),
    .PAR_EN   (par_en),
    .PAR_TYP  (par_typ),
    .STP_2    (stp_2),
    .busy     (busy),
    .rx_bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   brk_cnt = 0;
  int   cfg_p, cfg_len;
  logic cfg_pe, cfg_pt, cfg_stp2;
  logic mon_prev_valid = 1'b0;
  logic mon_prev_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.break_det) brk_cnt++;

  // Monitor: a frame is newly presented when valid rises, or stays high across an ack.
  always @(negedge clk) begin
    exp_t e;
    if (bus.Data_Valid && (!mon_prev_valid || mon_prev_ack)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_frame: got data=%h pe=%b fe=%b, none expected",
                 bus.P_Data, bus.parity_error, bus.framing_error);
      end else begin
        e = exp_q.pop_front();
        if (bus.P_Data !== e.d || bus.parity_error !== e.pe || bus.framing_error !== e.fe) begin
          n_err++;
          $display("FAIL frame: got data=%h pe=%b fe=%b, expected data=%h pe=%b fe=%b",
                   bus.P_Data, bus.parity_error, bus.framing_error, e.d, e.pe, e.fe);
        end
      end
    end
    mon_prev_valid = bus.Data_Valid;
    mon_prev_ack   = bus.Data_Ack;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic set_cfg(input int p, input int len, input logic pe, input logic pt, input logic s2);
    cfg_p = p; cfg_len = len; cfg_pe = pe; cfg_pt = pt; cfg_stp2 = s2;
    prescale = 6'(p); data_len = 5'(len); par_en = pe; par_typ = pt; stp_2 = s2;
  endtask

  // Drives one frame; scrambles the config inputs mid-frame to prove they are latched.
  task automatic send_frame(input logic [8:0] data, input logic par_bit,
                            input logic stop0, input logic stop1, input int spike_b);
    int   nb;
    logic v;
    logic [8:0] dv;
    dv = data;
    nb = 1 + cfg_len + (cfg_pe ? 1 : 0) + (cfg_stp2 ? 2 : 1);
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                          v = 1'b0;
      else if (b <= cfg_len)               v = dv[b-1];
      else if (cfg_pe && b == cfg_len + 1) v = par_bit;
      else if (b == nb - 1 && cfg_stp2)    v = stop1;
      else                                 v = stop0;
      for (int c = 0; c < cfg_p; c++) begin
        if (b == 1 && c == 0) begin
          prescale = (cfg_p == 8) ? 6'd16 : 6'd8;
          data_len = (cfg_len == 5) ? 5'd8 : 5'd5;
          par_en = ~cfg_pe; par_typ = ~cfg_pt; stp_2 = ~cfg_stp2;
        end
        rx_in = (b == spike_b && c == cfg_p / 2) ? ~v : v;
        tick(1);
      end
    end
    rx_in = 1'b1;
    set_cfg(cfg_p, cfg_len, cfg_pe, cfg_pt, cfg_stp2);
    tick(cfg_p);
  endtask

  task automatic ack_frame();
    bus.Data_Ack = 1'b1;
    tick(1);
    bus.Data_Ack = 1'b0;
  endtask

  task automatic ack_at(input int target);
    while (cyc < target) tick(1);
    bus.Data_Ack = 1'b1;
    tick(1);
    bus.Data_Ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int done;
    bus.Data_Ack = 1'b0;
    set_cfg(8, 8, 1'b1, 1'b0, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_valid", {31'd0, bus.Data_Valid}, 0);
    chk("reset_pdata", {23'd0, bus.P_Data}, 0);
    chk("reset_flags", {28'd0, bus.parity_error, bus.framing_error, bus.overrun_error, bus.break_det}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    tick(4);

    // 8E1, 0xA5 (four ones) with parity 0: clean frame.
    push(9'h0A5, 1'b0, 1'b0);
    send_frame(9'h0A5, 1'b0, 1'b1, 1'b1, -1);
    chk("a5_valid", {31'd0, bus.Data_Valid}, 1);
    ack_frame();
    chk("ack_clears_valid", {31'd0, bus.Data_Valid}, 0);

    // Odd parity selected, parity bit 0 sent: parity error.
    set_cfg(8, 8, 1'b1, 1'b1, 1'b0);
    push(9'h0A5, 1'b1, 1'b0);
    send_frame(9'h0A5, 1'b0, 1'b1, 1'b1, -1);
    ack_frame();
    chk("ack_clears_pe", {31'd0, bus.parity_error}, 0);

    // 5-bit data, no parity.
    set_cfg(8, 5, 1'b0, 1'b0, 1'b0);
    push(9'h015, 1'b0, 1'b0);
    send_frame(9'h015, 1'b0, 1'b1, 1'b1, -1);
    ack_frame();

    // 8N2 at 16x, second stop bit low: framing error; held unacked.
    set_cfg(16, 8, 1'b0, 1'b0, 1'b1);
    push(9'h05A, 1'b0, 1'b1);
    send_frame(9'h05A, 1'b0, 1'b1, 1'b0, -1);
    send_frame(9'h03C, 1'b0, 1'b1, 1'b1, -1);
    chk("overrun_set", {31'd0, bus.overrun_error}, 1);
    chk("overrun_keeps_data", {23'd0, bus.P_Data}, 32'h05A);
    chk("overrun_keeps_fe", {31'd0, bus.framing_error}, 1);
    ack_frame();
    chk("ack_clears_overrun", {31'd0, bus.overrun_error}, 0);
    chk("ack_clears_fe", {31'd0, bus.framing_error}, 0);

    // Ack landing exactly on the commit of the next frame.
    push(9'h011, 1'b0, 1'b0);
    send_frame(9'h011, 1'b0, 1'b1, 1'b1, -1);
    push(9'h022, 1'b0, 1'b0);
    k = cyc;
    fork
      send_frame(9'h022, 1'b0, 1'b1, 1'b1, -1);
      ack_at(k + 2 + 10 * 16 + 8 + 2);
    join
    chk("coincident_valid", {31'd0, bus.Data_Valid}, 1);
    chk("coincident_no_overrun", {31'd0, bus.overrun_error}, 0);
    ack_frame();

    // Short glitch on the start bit.
    set_cfg(16, 8, 1'b0, 1'b0, 1'b0);
    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    tick(2);
    chk("glitch_busy_rise", {31'd0, busy}, 1);
    done = 0;
    for (int i = 0; i < 12 && done == 0; i++) begin
      tick(1);
      if (!busy) done = 1;
    end
    chk("glitch_busy_idle", done, 1);
    tick(16);

    // One-cycle spike at the middle sample of data bit 2.
    push(9'h0C3, 1'b0, 1'b0);
    send_frame(9'h0C3, 1'b0, 1'b1, 1'b1, 3);
    ack_frame();

    // Break: 12 bit times low with 8E1 framing.
    set_cfg(16, 8, 1'b1, 1'b0, 1'b0);
    chk("no_break_yet", brk_cnt, 0);
    rx_in = 1'b0;
    tick(190);
    chk("break_busy", {31'd0, busy}, 1);
    chk("break_pulse_once", brk_cnt, 1);
    chk("break_no_valid", {31'd0, bus.Data_Valid}, 0);
    tick(2);
    rx_in = 1'b1;
    tick(6);
    chk("break_release_idle", {31'd0, busy}, 0);
    tick(16);

    // Reset in the middle of the data field with a frame held.
    set_cfg(8, 8, 1'b1, 1'b1, 1'b0);
    push(9'h077, 1'b0, 1'b0);
    send_frame(9'h077, 1'b1, 1'b1, 1'b1, -1);
    rx_in = 1'b0; tick(8);
    rx_in = 1'b1; tick(8);
    rx_in = 1'b0; tick(8);
    rx_in = 1'b1; tick(8);
    chk("mid_data_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    tick(2);
    chk("rst_valid", {31'd0, bus.Data_Valid}, 0);
    chk("rst_pdata", {23'd0, bus.P_Data}, 0);
    chk("rst_flags", {28'd0, bus.parity_error, bus.framing_error, bus.overrun_error, bus.break_det}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    tick(10);
    push(9'h096, 1'b0, 1'b0);
    send_frame(9'h096, 1'b1, 1'b1, 1'b1, -1);
    ack_frame();
    tick(4);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("break_total", brk_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
